// File: rtl/pc_4_adder_rv32i.sv
// Next-sequential-PC generator: combinational PCold + INC through a two-level CLA, plus registered copy.
// Optional wrap/misalign statistics outputs are enabled by defining PC4_ADDER_STATS_EN.
`timescale 1ns/1ps
module pc_4_adder_rv32i #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] INC      = XLEN'(4),
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] PCold,
  input  logic            en,
  output logic [XLEN-1:0] PC_4_inc,
  output logic            carry_out,
  output logic            misaligned,
  output logic [XLEN-1:0] PC_4_q,
  output logic            wrap_q
`ifdef PC4_ADDER_STATS_EN
  ,
  output logic [15:0]     wrap_cnt,
  output logic [0:0]      misalign_seen
`endif
);

  localparam int unsigned NG  = XLEN / 4;
  localparam logic        CIN = 1'b0;

  logic [XLEN-1:0] w_g;
  logic [XLEN-1:0] w_p;
  logic [XLEN-1:0] w_c;
  logic [NG-1:0]   w_gg;
  logic [NG-1:0]   w_gp;
  logic [NG:0]     w_gc;
  logic            w_run;

  logic [XLEN-1:0] r_pc_4_q;
  logic            r_wrap_q;

  // Bit generate/propagate and 4-bit group generate/propagate.
  always_comb begin
    w_g  = PCold & INC;
    w_p  = PCold ^ INC;
    w_gg = '0;
    w_gp = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      w_gg[k] = w_g[4*k+3]
              | (w_p[4*k+3] & w_g[4*k+2])
              | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
              | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
      w_gp[k] = &w_p[4*k +: 4];
    end
  end

  // Second level: each group carry is the flattened sum-of-products over all lower groups.
  always_comb begin
    w_gc  = '0;
    w_run = 1'b1;
    for (int unsigned k = 0; k < NG; k++) begin
      w_run = 1'b1;
      for (int unsigned jj = 0; jj <= k; jj++) begin
        w_gc[k+1] = w_gc[k+1] | (w_run & w_gg[k-jj]);
        w_run     = w_run & w_gp[k-jj];
      end
      w_gc[k+1] = w_gc[k+1] | (w_run & CIN);
    end
  end

  // Bit carries inside each group from that group's lookahead carry-in.
  always_comb begin
    w_c = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      w_c[4*k]   = w_gc[k];
      w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_gc[k]);
      w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+1] & w_p[4*k] & w_gc[k]);
      w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc[k]);
    end
  end

  assign PC_4_inc   = w_p ^ w_c;
  assign carry_out  = w_gc[NG];
  assign misaligned = |PCold[1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc_4_q <= RESET_PC;
      r_wrap_q <= 1'b0;
    end else if (en) begin
      r_pc_4_q <= PC_4_inc;
      r_wrap_q <= carry_out;
    end
  end

  assign PC_4_q = r_pc_4_q;
  assign wrap_q = r_wrap_q;

`ifdef PC4_ADDER_STATS_EN
  logic [15:0] r_wrap_cnt;
  logic        r_misalign_seen;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wrap_cnt      <= '0;
      r_misalign_seen <= 1'b0;
    end else if (en) begin
      if (carry_out && (r_wrap_cnt != '1))
        r_wrap_cnt <= r_wrap_cnt + 16'd1;
      if (misaligned)
        r_misalign_seen <= 1'b1;
    end
  end

  assign wrap_cnt      = r_wrap_cnt;
  assign misalign_seen = r_misalign_seen;
`endif

endmodule

// File: tb/tb_pc_4_adder_rv32i.sv
// Self-checking bench for pc_4_adder_rv32i: directed cases then randomized steps vs. an arithmetic model.
`timescale 1ns/1ps
module tb_pc_4_adder_rv32i;

  localparam logic [31:0] TB_RESET_PC = 32'h0040_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] PCold;
  logic        en;
  logic [31:0] PC_4_inc;
  logic        carry_out;
  logic        misaligned;
  logic [31:0] PC_4_q;
  logic        wrap_q;
`ifdef PC4_ADDER_STATS_EN
  logic [15:0] wrap_cnt;
  logic [0:0]  misalign_seen;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state for the registered outputs.
  logic [31:0] m_q;
  logic        m_wrap;
  logic [15:0] m_cnt;
  logic        m_seen;

  pc_4_adder_rv32i #(
    .XLEN    (32),
    .INC     (32'd4),
    .RESET_PC(TB_RESET_PC)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .PCold     (PCold),
    .en        (en),
    .PC_4_inc  (PC_4_inc),
    .carry_out (carry_out),
    .misaligned(misaligned),
    .PC_4_q    (PC_4_q),
    .wrap_q    (wrap_q)
`ifdef PC4_ADDER_STATS_EN
    ,
    .wrap_cnt     (wrap_cnt),
    .misalign_seen(misalign_seen)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_comb();
    logic [32:0] s;
    s = {1'b0, PCold} + 33'd4;
    check("PC_4_inc",   PC_4_inc,              s[31:0]);
    check("carry_out",  {31'b0, carry_out},    {31'b0, s[32]});
    check("misaligned", {31'b0, misaligned},   {31'b0, (PCold[1:0] != 2'b00)});
  endtask

  task automatic check_regs();
    check("PC_4_q", PC_4_q,          m_q);
    check("wrap_q", {31'b0, wrap_q}, {31'b0, m_wrap});
`ifdef PC4_ADDER_STATS_EN
    check("wrap_cnt",      {16'b0, wrap_cnt},      {16'b0, m_cnt});
    check("misalign_seen", {31'b0, misalign_seen}, {31'b0, m_seen});
`endif
  endtask

  task automatic tick();
    logic [32:0] s;
    logic        r, e, mis;
    s   = {1'b0, PCold} + 33'd4;
    r   = reset;
    e   = en;
    mis = (PCold[1:0] != 2'b00);
    @(posedge clock);
    if (r) begin
      m_q = TB_RESET_PC; m_wrap = 1'b0; m_cnt = '0; m_seen = 1'b0;
    end else if (e) begin
      m_q = s[31:0]; m_wrap = s[32];
      if (s[32] && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (mis) m_seen = 1'b1;
    end
    #1;
  endtask

  initial begin
    m_q = 'x; m_wrap = 'x; m_cnt = 'x; m_seen = 'x;
    reset = 1'b1; en = 1'b0; PCold = 32'h0000_0000;
    tick(); tick();
    check("reset PC_4_q", PC_4_q, TB_RESET_PC);
    check("reset wrap_q", {31'b0, wrap_q}, 32'd0);
    check_regs();
    check("zero PC_4_inc", PC_4_inc, 32'h0000_0004);
    check_comb();

    // Combinational path with no clock edge involved.
    reset = 1'b0;
    PCold = 32'h0000_0004; #10;
    check("pc4 PC_4_inc", PC_4_inc, 32'h0000_0008);
    check_comb();
    PCold = 32'h1234_5678; #10;
    check("pc1234 PC_4_inc", PC_4_inc, 32'h1234_567C);
    check_comb();

    // Wrap at the top of the address space.
    PCold = 32'hFFFF_FFFC; en = 1'b1; #1;
    check("wrap PC_4_inc", PC_4_inc, 32'h0000_0000);
    check("wrap carry_out", {31'b0, carry_out}, 32'd1);
    tick();
    check("wrap PC_4_q", PC_4_q, 32'h0000_0000);
    check("wrap wrap_q", {31'b0, wrap_q}, 32'd1);
    check_regs();

    // Misaligned PC still adds on all bits.
    PCold = 32'hABCD_EF01; en = 1'b0; #1;
    check("mis PC_4_inc", PC_4_inc, 32'hABCD_EF05);
    check("mis flag", {31'b0, misaligned}, 32'd1);
    PCold = 32'hFFFF_FFFF; #1;
    check_comb();

    // Reset overrides enable; combinational path unaffected.
    reset = 1'b1; en = 1'b1; PCold = 32'h1234_5678; #1;
    check("rst PC_4_inc pre", PC_4_inc, 32'h1234_567C);
    tick();
    check("rst PC_4_q", PC_4_q, TB_RESET_PC);
    check("rst wrap_q", {31'b0, wrap_q}, 32'd0);
    check("rst PC_4_inc post", PC_4_inc, 32'h1234_567C);
    reset = 1'b0;
    tick();
    check("post-rst PC_4_q", PC_4_q, 32'h1234_567C);
    check_regs();

    // Hold while en is low.
    PCold = 32'h0000_0004; en = 1'b1;
    tick();
    check("load PC_4_q", PC_4_q, 32'h0000_0008);
    en = 1'b0; PCold = 32'h0000_0010; #1;
    check("hold PC_4_inc", PC_4_inc, 32'h0000_0014);
    for (int i = 0; i < 3; i++) tick();
    check("hold PC_4_q", PC_4_q, 32'h0000_0008);
    check_regs();

    // Randomized steps, biased toward the wrap region.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       PCold = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        1:       PCold = $urandom & 32'hFFFF_FFFC;
        default: PCold = $urandom;
      endcase
      en    = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 19) == 0);
      #1;
      check_comb();
      tick();
      check_regs();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
